// File: rtl/shift_chain_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_chain_loader_pkg
// Purpose  : Shared types and default constants for the serial configuration
//            chain loader of the ring-oscillator entropy tile.
// Contents : state_e      - loader FSM states
//            CHAIN_WIDTH  - default chain length in bits
//            SHIFT_DIV    - default clk cycles per shift_clk phase
// Revision : 1.0 - initial release
// ============================================================================
package shift_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int CHAIN_WIDTH = 12;
    localparam int SHIFT_DIV   = 4;

endpackage
`default_nettype wire

// File: rtl/shift_chain_loader_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2_zeptobars
// Purpose  : Two-flop synchronizer bringing the chain's far-end output into
//            the clk domain. Both stages reset to 0.
// Ports    : clk   in  - destination clock
//            rst   in  - asynchronous active-high reset
//            d_in  in  - asynchronous input
//            d_out out - synchronized output
// Revision : 1.0 - initial release
// ============================================================================
module sync2_zeptobars (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/shift_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : shift_chain_loader
// Purpose  : Accepts a parallel configuration word over valid/ready and shifts
//            it MSB-first into the oscillator tile's serial chain so that word
//            bit i ends up in chain bit i. Each bit gets DIV cycles of
//            shift_clk low (data set up) then DIV cycles high.
// Option   : SHIFT_CHAIN_LOADER_READBACK_EN - adds a second shift pass that
//            compares the chain's far-end output against the word; err flags
//            any mismatch. Undefined: LOAD goes straight to DONE, err is 0.
// Ports    : clk, rst (async, active-high)
//            cfg_data/cfg_valid/cfg_ready - configuration word handshake
//            shift_clk/shift_dta          - chain clock and serial data
//            shift_sdo                    - chain far-end output (readback)
//            busy, done (1-cycle pulse), err (sticky until next accept)
// Revision : 1.0 - initial release
// ============================================================================
module shift_chain_loader
    import shift_chain_loader_pkg::*;
#(
    parameter int WIDTH = CHAIN_WIDTH,
    parameter int DIV   = SHIFT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             shift_clk,
    output logic             shift_dta,
    input  logic             shift_sdo,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int C_BIT_W   = $clog2(WIDTH + 1);
    localparam int C_PHASE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [C_BIT_W-1:0]   C_BIT_LAST   = C_BIT_W'(WIDTH - 1);
    localparam logic [C_PHASE_W-1:0] C_PHASE_LAST = C_PHASE_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("shift_chain_loader: DIV must be at least 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;     // accepted word, kept for VERIFY
    logic [WIDTH-1:0]   tx_q, tx_d;         // MSB is the bit on shift_dta
    logic [C_BIT_W-1:0] bit_q, bit_d;
    logic [C_PHASE_W-1:0] phase_q, phase_d;
    logic shift_clk_q, shift_clk_d;
    logic shift_dta_q, shift_dta_d;
    logic cfg_ready_q, cfg_ready_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic [WIDTH-1:0] w_tx_next;
    logic             w_phase_last;
    logic             w_bit_last;

`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    logic w_sdo_sync;

    sync2_zeptobars u_sdo_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (shift_sdo),
        .d_out (w_sdo_sync)
    );
`else
    logic w_unused_sdo;
    assign w_unused_sdo = shift_sdo;
`endif

    assign w_tx_next    = tx_q << 1;
    assign w_phase_last = (phase_q == C_PHASE_LAST);
    assign w_bit_last   = (bit_q == C_BIT_LAST);

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        tx_d        = tx_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        shift_clk_d = shift_clk_q;
        shift_dta_d = shift_dta_q;
        cfg_ready_d = cfg_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_ready_q) begin
                    state_d     = LOAD;
                    word_d      = cfg_data;
                    tx_d        = cfg_data;
                    bit_d       = '0;
                    phase_d     = '0;
                    shift_clk_d = 1'b0;
                    shift_dta_d = cfg_data[WIDTH-1];
                    cfg_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                end
            end

            LOAD, VERIFY: begin
                if (!w_phase_last) begin
                    phase_d = phase_q + 1'b1;
                end else begin
                    phase_d = '0;
                    if (!shift_clk_q) begin
                        // End of low phase: raise the clock. In VERIFY this is
                        // also the sample point, with the chain settled for
                        // well over the synchronizer latency.
                        shift_clk_d = 1'b1;
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
                        if (state_q == VERIFY && w_sdo_sync != shift_dta_q) begin
                            err_d = 1'b1;
                        end
`endif
                    end else begin
                        // End of high phase: falling edge presents the next bit.
                        shift_clk_d = 1'b0;
                        if (!w_bit_last) begin
                            bit_d       = bit_q + 1'b1;
                            tx_d        = w_tx_next;
                            shift_dta_d = w_tx_next[WIDTH-1];
                        end else begin
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
                            if (state_q == LOAD) begin
                                // Replay the word with no gap; the chain's
                                // far end now emits it in transmit order.
                                state_d     = VERIFY;
                                bit_d       = '0;
                                tx_d        = word_q;
                                shift_dta_d = word_q[WIDTH-1];
                            end else begin
                                state_d     = DONE;
                                busy_d      = 1'b0;
                                done_d      = 1'b1;
                                shift_dta_d = 1'b0;
                            end
`else
                            state_d     = DONE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            shift_dta_d = 1'b0;
`endif
                        end
                    end
                end
            end

            DONE: begin
                state_d     = IDLE;
                cfg_ready_d = 1'b1;
            end

            default: begin
                state_d     = IDLE;
                cfg_ready_d = 1'b1;
                busy_d      = 1'b0;
                shift_clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            tx_q        <= '0;
            bit_q       <= '0;
            phase_q     <= '0;
            shift_clk_q <= 1'b0;
            shift_dta_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            tx_q        <= tx_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            shift_clk_q <= shift_clk_d;
            shift_dta_q <= shift_dta_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign shift_clk = shift_clk_q;
    assign shift_dta = shift_dta_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_chain_loader
// Purpose  : Self-checking bench for shift_chain_loader (WIDTH=12, DIV=4).
//            Models the tile chain as a 12-bit shift register clocked by
//            shift_clk with shift_sdo = bit 11, optionally with bit 5 stuck 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_chain_loader;

    localparam int WIDTH = 12;
    localparam int DIV   = 4;
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    localparam int EXP_LAT = 4 * DIV * WIDTH;
`else
    localparam int EXP_LAT = 2 * DIV * WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] cfg_data = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             shift_clk;
    logic             shift_dta;
    logic             shift_sdo;
    logic             busy;
    logic             done;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [11:0] chain = '0;
    bit          stuck5 = 1'b0;
    int          nbits = 0;
    logic        dta_seq [0:31];

    shift_chain_loader #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .shift_clk (shift_clk),
        .shift_dta (shift_dta),
        .shift_sdo (shift_sdo),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    always @(posedge shift_clk) begin
        if (nbits < 32) dta_seq[nbits] = shift_dta;
        nbits = nbits + 1;
        chain = {chain[10:0], shift_dta};
        if (stuck5) chain[5] = 1'b0;
    end

    assign shift_sdo = chain[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [11:0] w, output int acc);
        @(negedge clk);
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({shift_clk, shift_dta, cfg_ready, busy, done, err} !== 6'b001000) begin
            n_errors++;
            $display("FAIL reset_outputs: got clk,dta,rdy,busy,done,err=%b expected 001000",
                     {shift_clk, shift_dta, cfg_ready, busy, done, err});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b expected rdy=1 busy=0", cfg_ready, busy);
        end
    endtask

    task automatic test_load_a5c;
        int acc, lat, k;
        logic [11:0] seq;
        nbits = 0;
        send_word(12'hA5C, acc);
        n_checks++;
        if (shift_dta !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL a5c_accept: got dta=%b busy=%b rdy=%b expected dta=1 busy=1 rdy=0",
                     shift_dta, busy, cfg_ready);
        end
        k = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (shift_clk === 1'b1) begin
                k = cyc - acc;
                break;
            end
        end
        n_checks++;
        if (k !== DIV) begin
            n_errors++;
            $display("FAIL a5c_first_rise: got %0d cycles after accept expected %0d", k, DIV);
        end
        wait_done(acc, lat);
        n_checks++;
        if (lat !== EXP_LAT) begin
            n_errors++;
            $display("FAIL a5c_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        n_checks++;
        if (chain !== 12'hA5C) begin
            n_errors++;
            $display("FAIL a5c_chain: got %h expected a5c", chain);
        end
        seq = '0;
        for (int i = 0; i < 12; i++) seq = {seq[10:0], dta_seq[i]};
        n_checks++;
        if (seq !== 12'hA5C) begin
            n_errors++;
            $display("FAIL a5c_dta_sequence: got %h expected a5c (1,0,1,0,0,1,0,1,1,1,0,0)", seq);
        end
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || shift_clk !== 1'b0) begin
            n_errors++;
            $display("FAIL a5c_done_state: got err=%b busy=%b clk=%b expected 0 0 0", err, busy, shift_clk);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL a5c_idle_return: got rdy=%b done=%b expected rdy=1 done=0", cfg_ready, done);
        end
    endtask

    task automatic test_back_to_back;
        int acc, acc2, lat, early;
        nbits = 0;
        send_word(12'h0F0, acc);
        repeat (10) @(negedge clk);
        cfg_data  = 12'hFFF;
        cfg_valid = 1'b1;
        early = 0;
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = cyc - acc;
                break;
            end
            if (cfg_ready !== 1'b0) early++;
        end
        n_checks++;
        if (early !== 0 || lat !== EXP_LAT) begin
            n_errors++;
            $display("FAIL b2b_busy_ready: got ready-high cycles=%0d latency=%0d expected 0 and %0d",
                     early, lat, EXP_LAT);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_idle: got rdy=%b expected 1", cfg_ready);
        end
        @(posedge clk);
        #1;
        acc2 = cyc;
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || shift_dta !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_accept: got busy=%b rdy=%b dta=%b expected 1 0 1", busy, cfg_ready, shift_dta);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_done(acc2, lat);
        n_checks++;
        if (lat !== EXP_LAT || chain !== 12'hFFF) begin
            n_errors++;
            $display("FAIL b2b_second_load: got latency=%0d chain=%h expected %0d fff", lat, chain, EXP_LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midload;
        int acc, lat, dc;
        send_word(12'hABC, acc);
        repeat (40) @(posedge clk);
        #3;
        dc = done_cnt;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({shift_clk, shift_dta, cfg_ready, busy, done, err} !== 6'b001000) begin
            n_errors++;
            $display("FAIL midload_reset_outputs: got clk,dta,rdy,busy,done,err=%b expected 001000",
                     {shift_clk, shift_dta, cfg_ready, busy, done, err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        n_checks++;
        if (done_cnt !== dc || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midload_no_done: got done pulses=%0d busy=%b expected 0 pulses busy=0",
                     done_cnt - dc, busy);
        end
        nbits = 0;
        send_word(12'h123, acc);
        wait_done(acc, lat);
        n_checks++;
        if (lat !== EXP_LAT || chain !== 12'h123) begin
            n_errors++;
            $display("FAIL midload_reload: got latency=%0d chain=%h expected %0d 123", lat, chain, EXP_LAT);
        end
        @(negedge clk);
    endtask

`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
    task automatic test_readback_clean;
        int acc, lat;
        send_word(12'h3C7, acc);
        wait_done(acc, lat);
        n_checks++;
        if (lat !== 192 || err !== 1'b0 || chain !== 12'h3C7) begin
            n_errors++;
            $display("FAIL rb_clean: got latency=%0d err=%b chain=%h expected 192 0 3c7", lat, err, chain);
        end
        @(negedge clk);
    endtask

    task automatic test_readback_stuck;
        int acc, lat;
        stuck5 = 1'b1;
        send_word(12'hFFF, acc);
        wait_done(acc, lat);
        n_checks++;
        if (lat !== 192 || err !== 1'b1) begin
            n_errors++;
            $display("FAIL rb_stuck_err: got latency=%0d err=%b expected 192 1", lat, err);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL rb_err_sticky: got err=%b expected 1", err);
        end
        stuck5 = 1'b0;
        send_word(12'h3C7, acc);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL rb_err_clear_on_accept: got err=%b expected 0", err);
        end
        wait_done(acc, lat);
        n_checks++;
        if (err !== 1'b0 || chain !== 12'h3C7) begin
            n_errors++;
            $display("FAIL rb_recover: got err=%b chain=%h expected 0 3c7", err, chain);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_sdo_ignored;
        int acc, lat;
        stuck5 = 1'b1;
        send_word(12'hFFF, acc);
        wait_done(acc, lat);
        n_checks++;
        if (lat !== 96 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL no_rb_err_tied: got latency=%0d err=%b expected 96 0", lat, err);
        end
        stuck5 = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_load_a5c();
        test_back_to_back();
        test_reset_midload();
`ifdef SHIFT_CHAIN_LOADER_READBACK_EN
        test_readback_clean();
        test_readback_stuck();
`else
        test_sdo_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_chain_loader.md
# shift_chain_loader

Host-side transmitter for the 12-bit serial configuration chain of the ring-oscillator entropy tile. It accepts a parallel configuration word over a valid/ready handshake and drives the chain's `shift_clk`/`shift_dta` pins MSB-first, so that after loading, word bit i sits in chain bit i. When compiled with readback, it also runs a second pass that captures the chain's serial output and flags any mismatch. It sits in the harness/controller logic that configures the oscillator tile before frequency or random-bit measurements.

## Interface
- `WIDTH`, default 12: chain length in bits (≥1).
- `DIV`, default 4: `clk` cycles per `shift_clk` phase (low and high each); DIV < 2 is an elaboration error.
- `clk` in 1: system clock; all logic rises on `clk`.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_data` in WIDTH: configuration word, sampled on handshake.
- `cfg_valid` in 1: word available.
- `cfg_ready` out 1: loader idle and able to accept.
- `shift_clk` out 1: chain shift clock; the chain samples on its rising edge.
- `shift_dta` out 1: chain serial data.
- `shift_sdo` in 1: chain far-end output (chain bit WIDTH-1), asynchronous to `clk`; used only with readback.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse at the end of a load.
- `err` out 1: readback mismatch, sticky until the next accept; tied 0 without readback.

## Operation
- States: IDLE → LOAD → (VERIFY, readback only) → DONE → IDLE.
- IDLE: `cfg_ready`=1. `cfg_valid`&`cfg_ready` at an edge latches `cfg_data`, clears `err`, and enters LOAD.
- LOAD: shifts out WIDTH bits, from `cfg_data[WIDTH-1]` down to `cfg_data[0]`. Each bit is a low phase of DIV cycles with `shift_dta` set, followed by a high phase of DIV cycles with `shift_clk`=1.
- A bit counter of width $clog2(WIDTH+1) and a phase counter of width $clog2(DIV) are used; neither counter wraps inside a pass.
- VERIFY: shifts the same word again. At the last cycle of each low phase, the synchronized `shift_sdo` is compared with the bit currently on `shift_dta`. The chain still holds the word, so the expected bit order equals the transmit order. Any mismatch sets `err`.
- DONE: one cycle with `done`=1, `cfg_ready`=0, `shift_clk`=0.
- `cfg_valid` while not in IDLE: ignored; `cfg_ready` is low and the word must be held by the sender.
- Reset values: `shift_clk`=0, `shift_dta`=0, `cfg_ready`=1, `busy`=0, `done`=0, `err`=0, state IDLE.
- Reset mid-load: all outputs return to their reset values immediately. The chain is left partially loaded, and no `done` is issued.
- `busy`=1 exactly in LOAD and VERIFY.

## Timing
- All outputs are registered. The accept edge is T.
- `shift_dta` = MSB from T. `shift_clk` rises at T+DIV and falls at T+2·DIV, when the next bit is also presented.
- This gives DIV cycles of setup and DIV cycles of hold around every rising edge.
- Bit k rises at T+(2k+1)·DIV.
- The last fall is at T+2·DIV·WIDTH. `done` is high for the cycle following that edge, and `cfg_ready`=1 one cycle later.
- Without readback, the defaults give 96 cycles from accept to `done`.
- With readback, VERIFY starts at the final LOAD fall with no gap. `done` follows at T+4·DIV·WIDTH, which is 192 cycles with the defaults. `err` is valid at `done`.
- `shift_sdo` passes through a 2-flop synchronizer. With DIV ≥ 2 the sample is taken at least 2·DIV−1 cycles after the chain updated.
- Back-to-back loads: minimum spacing between accepts is 2·DIV·WIDTH+2 cycles.

## Configuration
- `SHIFT_CHAIN_LOADER_READBACK_EN` defined: VERIFY state, `shift_sdo` synchronizer and comparator present; `err` is functional.
- Macro undefined: LOAD goes directly to DONE, `shift_sdo` is unused, and `err` is constant 0.

## Structure
- Package `shift_chain_loader_pkg` holds:
  - the state enum (IDLE, LOAD, VERIFY, DONE);
  - default constants `CHAIN_WIDTH`=12 and `SHIFT_DIV`=4.
- Sub-module `sync2_zeptobars`: a two-flop synchronizer with async reset to 0, instantiated only under the macro.

## Test plan
- The bench models the chain as a 12-bit shift register on the `shift_clk` rising edge, with `shift_sdo` = bit 11.
- Load 0xA5C with DIV=4: after `done` (96 cycles after accept), the chain holds 0xA5C. `shift_dta` sequence is 1,0,1,0,0,1,0,1,1,1,0,0.
- Assert `cfg_valid` with 0xFFF during a busy load: `cfg_ready` stays 0 and 0xFFF is accepted in the cycle after the first load returns to IDLE. The chain ends at 0xFFF.
- Reset at cycle 40 of a load: outputs are at reset values in the same cycle, no `done` is issued, and a following 0x123 load completes correctly.
- Readback enabled, clean chain, 0x3C7: `done` at 192 cycles, `err`=0, and the chain holds 0x3C7.
- Readback enabled, chain bit 5 stuck at 0, load 0xFFF: `err`=1 at `done`. `err` stays 1 until the next accept clears it.
